// File: rtl/isa_pkg.sv
// ISA constants, field positions and LM/SM sequencer state type.
// Shared by the ID-stage decode blocks.
package isa_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int RB_MSB   = 8;
  localparam int RB_LSB   = 6;
  localparam int RC_MSB   = 5;
  localparam int RC_LSB   = 3;
  localparam int IMM6_MSB = 5;
  localparam int IMM9_MSB = 8;
  localparam int MASK_MSB = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } lmsm_state_e;

  function automatic logic is_lmsm(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_pick.sv
// Priority picker over an 8-bit register mask.
// Ports: mask_i in; idx_o chosen bit, clr_o one-hot of it, one_o single bit set.
module lmsm_pick #(
  parameter bit ORDER_MSB_FIRST = 1'b0
) (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic [7:0] clr_o,
  output logic       one_o
);

  always_comb begin
    idx_o = '0;
    if (ORDER_MSB_FIRST) begin
      // later hits overwrite: highest set bit wins
      for (int i = 0; i < 8; i++)
        if (mask_i[i]) idx_o = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (mask_i[i]) idx_o = 3'(i);
    end
    clr_o = (mask_i != '0) ? (8'd1 << idx_o) : 8'd0;
    one_o = (mask_i != '0) &&
            ((mask_i & (mask_i - 8'd1)) == '0);
  end

endmodule

// File: rtl/id_lmsm_seq.sv
// ID-stage field extract and LM/SM expander into one transfer per cycle.
// Ports: ir_id/valid_id/stall_in/flush in; reg/imm fields, uop flags, hold_ifid out.
module id_lmsm_seq
  import isa_pkg::*;
#(
  parameter bit ORDER_MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir_id,
  input  logic        valid_id,
  input  logic        stall_in,
  input  logic        flush,
  output logic [2:0]  reg1add_id,
  output logic [2:0]  reg2add_id,
  output logic [2:0]  reg3add_id,
  output logic [5:0]  imm6_id,
  output logic [8:0]  imm9_id,
  output logic        is_lm,
  output logic        is_sm,
  output logic        uop_valid,
  output logic        last_uop,
  output logic        hold_ifid
);

  lmsm_state_e state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  ra_q, ra_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  op_q, op_d;

  logic [3:0]  opc;
  logic        seq;
  logic        micro;
  logic [7:0]  pmask;
  logic [2:0]  pidx;
  logic [7:0]  pclr;
  logic        pone;
  logic        pany;
  logic [3:0]  cur_op;
  logic [2:0]  cur_ra;
  logic [2:0]  cur_k;

  assign opc    = ir_id[OPC_MSB:OPC_LSB];
  assign seq    = (state_q == SEQ);
  assign micro  = seq || (valid_id && is_lmsm(opc));
  assign pmask  = seq ? mask_q : ir_id[MASK_MSB:0];
  assign pany   = (pmask != '0);
  assign cur_op = seq ? op_q : opc;
  assign cur_ra = seq ? ra_q : ir_id[RA_MSB:RA_LSB];
  assign cur_k  = seq ? k_q : 3'd0;

  lmsm_pick #(
    .ORDER_MSB_FIRST(ORDER_MSB_FIRST)
  ) u_pick (
    .mask_i(pmask),
    .idx_o (pidx),
    .clr_o (pclr),
    .one_o (pone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ra_q    <= '0;
      k_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ra_q    <= ra_d;
      k_q     <= k_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ra_d       = ra_q;
    k_d        = k_q;
    op_d       = op_q;
    reg1add_id = ir_id[RA_MSB:RA_LSB];
    reg2add_id = ir_id[RB_MSB:RB_LSB];
    reg3add_id = ir_id[RC_MSB:RC_LSB];
    imm6_id    = ir_id[IMM6_MSB:0];
    imm9_id    = ir_id[IMM9_MSB:0];
    uop_valid  = valid_id;
    last_uop   = 1'b1;
    hold_ifid  = 1'b0;
    is_lm      = 1'b0;
    is_sm      = 1'b0;

    if (micro) begin
      reg1add_id = cur_ra;
      reg2add_id = '0;
      reg3add_id = '0;
      imm6_id    = {3'b000, cur_k};
      imm9_id    = '0;
      uop_valid  = pany;
      last_uop   = pone || !pany;
      hold_ifid  = pany && !pone;
      is_lm      = pany && (cur_op == OP_LM);
      is_sm      = pany && (cur_op == OP_SM);
      if (cur_op == OP_LM) reg3add_id = pidx;
      else                 reg2add_id = pidx;
      if (pany && !pone) begin
        state_d = SEQ;
        mask_d  = pmask & ~pclr;
        ra_d    = cur_ra;
        op_d    = cur_op;
        k_d     = cur_k + 3'd1;
      end else begin
        state_d = IDLE;
        mask_d  = '0;
        k_d     = '0;
      end
    end

    if (stall_in) begin
      state_d   = state_q;
      mask_d    = mask_q;
      ra_d      = ra_q;
      k_d       = k_q;
      op_d      = op_q;
      hold_ifid = 1'b1;
    end

    if (flush) begin
      state_d   = IDLE;
      mask_d    = '0;
      k_d       = '0;
      uop_valid = 1'b0;
      hold_ifid = 1'b0;
    end

    // a squashed slot is not a transfer
    is_lm = is_lm && uop_valid;
    is_sm = is_sm && uop_valid;

    if (!rst_n) begin
      uop_valid = 1'b0;
      hold_ifid = 1'b0;
      is_lm     = 1'b0;
      is_sm     = 1'b0;
      last_uop  = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_lmsm_seq.sv
// Randomized and directed bench for id_lmsm_seq against a queue model.
// Model keeps the list of pending transfer registers per LM/SM.
module tb_id_lmsm_seq;

  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir_id;
  logic        valid_id;
  logic        stall_in;
  logic        flush;
  logic [2:0]  reg1add_id;
  logic [2:0]  reg2add_id;
  logic [2:0]  reg3add_id;
  logic [5:0]  imm6_id;
  logic [8:0]  imm9_id;
  logic        is_lm;
  logic        is_sm;
  logic        uop_valid;
  logic        last_uop;
  logic        hold_ifid;

  int n_chk = 0;
  int n_err = 0;

  int       q[$];
  int       m_ra;
  int       m_k;
  logic [3:0] m_op;

  always #5 clk = ~clk;

  id_lmsm_seq #(
    .ORDER_MSB_FIRST(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_id     (ir_id),
    .valid_id  (valid_id),
    .stall_in  (stall_in),
    .flush     (flush),
    .reg1add_id(reg1add_id),
    .reg2add_id(reg2add_id),
    .reg3add_id(reg3add_id),
    .imm6_id   (imm6_id),
    .imm9_id   (imm9_id),
    .is_lm     (is_lm),
    .is_sm     (is_sm),
    .uop_valid (uop_valid),
    .last_uop  (last_uop),
    .hold_ifid (hold_ifid)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive one cycle, compare against the model, advance the model
  task automatic step(input logic [15:0] ir, input logic v,
                      input logic st, input logic fl);
    int lst[$];
    int ra, k, n;
    logic [3:0] op;
    bit mic;
    logic e_uv, e_hold, e_last;
    @(negedge clk);
    ir_id = ir; valid_id = v; stall_in = st; flush = fl;
    #1;
    mic = 1'b0;
    if (q.size() > 0) begin
      lst = q; ra = m_ra; op = m_op; k = m_k; mic = 1'b1;
    end else if (v && (ir[15:12] == LM || ir[15:12] == SM)) begin
      lst = {};
      for (int i = 0; i < 8; i++) if (ir[i]) lst.push_back(i);
      ra = int'(ir[11:9]); op = ir[15:12]; k = 0; mic = 1'b1;
    end
    if (mic) begin
      n = lst.size();
      e_uv   = (n > 0) && !fl;
      e_last = (n <= 1);
      e_hold = fl ? 1'b0 : (st ? 1'b1 : (n > 1));
      chk("uop_valid", 16'(uop_valid), 16'(e_uv));
      chk("hold", 16'(hold_ifid), 16'(e_hold));
      chk("last", 16'(last_uop), 16'(e_last));
      chk("is_lm", 16'(is_lm), 16'(e_uv && op == LM));
      chk("is_sm", 16'(is_sm), 16'(e_uv && op == SM));
      if (e_uv) begin
        chk("ra", 16'(reg1add_id), 16'(ra));
        chk("k", 16'(imm6_id), 16'(k));
        chk("r3", 16'(reg3add_id), 16'(op == LM ? lst[0] : 0));
        chk("r2", 16'(reg2add_id), 16'(op == SM ? lst[0] : 0));
      end
      if (fl) q.delete();
      else if (!st) begin
        if (n > 1) begin
          q = lst[1:$]; m_ra = ra; m_op = op; m_k = k + 1;
        end else q.delete();
      end
    end else begin
      chk("uop_valid", 16'(uop_valid), 16'(v && !fl));
      chk("hold", 16'(hold_ifid), 16'(st && !fl));
      chk("last", 16'(last_uop), 16'd1);
      chk("is_lm", 16'(is_lm), 16'd0);
      chk("is_sm", 16'(is_sm), 16'd0);
      chk("r1", 16'(reg1add_id), 16'(ir[11:9]));
      chk("r2", 16'(reg2add_id), 16'(ir[8:6]));
      chk("r3", 16'(reg3add_id), 16'(ir[5:3]));
      chk("imm6", 16'(imm6_id), 16'(ir[5:0]));
      chk("imm9", 16'(imm9_id), 16'(ir[8:0]));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; valid_id = 1'b0; stall_in = 1'b0; flush = 1'b0;
    #1;
    chk("rst_uv", 16'(uop_valid), 16'd0);
    chk("rst_hold", 16'(hold_ifid), 16'd0);
    chk("rst_lm", 16'(is_lm), 16'd0);
    chk("rst_last", 16'(last_uop), 16'd0);
    q.delete(); m_k = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ir;
    logic [7:0]  msk;
    rst_n = 1'b0; ir_id = '0; valid_id = 1'b0;
    stall_in = 1'b0; flush = 1'b0;
    m_ra = 0; m_k = 0; m_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_uv", 16'(uop_valid), 16'd0);
    chk("reset_hold", 16'(hold_ifid), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD pass-through
    step(16'h05D8, 1'b1, 1'b0, 1'b0);
    chk("add_r1", 16'(reg1add_id), 16'd2);
    chk("add_r2", 16'(reg2add_id), 16'd7);
    chk("add_r3", 16'(reg3add_id), 16'd3);

    // LM RA=3 mask 0x25
    step(16'h6625, 1'b1, 1'b0, 1'b0);
    chk("lm0_r3", 16'(reg3add_id), 16'd0);
    chk("lm0_h", 16'(hold_ifid), 16'd1);
    step(16'h6625, 1'b1, 1'b0, 1'b0);
    chk("lm1_r3", 16'(reg3add_id), 16'd2);
    chk("lm1_k", 16'(imm6_id), 16'd1);
    step(16'h6625, 1'b1, 1'b0, 1'b0);
    chk("lm2_r3", 16'(reg3add_id), 16'd5);
    chk("lm2_k", 16'(imm6_id), 16'd2);
    chk("lm2_h", 16'(hold_ifid), 16'd0);
    chk("lm2_r1", 16'(reg1add_id), 16'd3);

    // SM single and empty mask
    step(16'h7280, 1'b1, 1'b0, 1'b0);
    chk("sm1_r2", 16'(reg2add_id), 16'd7);
    chk("sm1_sm", 16'(is_sm), 16'd1);
    step(16'h7200, 1'b1, 1'b0, 1'b0);
    chk("sm0_uv", 16'(uop_valid), 16'd0);

    // LM 0xFF, stall two cycles at k=3
    for (int c = 0; c < 10; c++) begin
      step(16'h60FF, 1'b1, (c == 3 || c == 4), 1'b0);
      if (c >= 3 && c <= 5) chk("stall_k", 16'(imm6_id), 16'd3);
    end
    chk("ff_last", 16'(last_uop), 16'd1);
    chk("ff_k7", 16'(imm6_id), 16'd7);

    // SM 0x0F flushed at k=1, then ADD passes through
    step(16'h720F, 1'b1, 1'b0, 1'b0);
    step(16'h720F, 1'b1, 1'b0, 1'b1);
    chk("fl_uv", 16'(uop_valid), 16'd0);
    step(16'h05D8, 1'b1, 1'b0, 1'b0);
    chk("fl_next_r3", 16'(reg3add_id), 16'd3);

    // reset mid-sequence, then LM 0x03 restarts at k=0
    step(16'h60FF, 1'b1, 1'b0, 1'b0);
    step(16'h60FF, 1'b1, 1'b0, 1'b0);
    pulse_reset();
    step(16'h6003, 1'b1, 1'b0, 1'b0);
    chk("rs_k", 16'(imm6_id), 16'd0);
    chk("rs_r3", 16'(reg3add_id), 16'd0);
    step(16'h6003, 1'b1, 1'b0, 1'b0);
    chk("rs_r3b", 16'(reg3add_id), 16'd1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 4) begin
        ir[15:12] = $urandom_range(0, 1) ? LM : SM;
        msk = 8'($urandom);
        if ($urandom_range(0, 3) == 0) msk = msk & 8'($urandom);
        if ($urandom_range(0, 7) == 0) msk = 8'd0;
        ir[7:0] = msk;
      end
      step(ir, $urandom_range(0, 9) != 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 12) == 0);
      if (c == 300) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/id_lmsm_seq.md
Name: id_lmsm_seq

Overview:
Decode-side producer for the ID/RD pipeline register. It extracts register addresses and immediates from the instruction word held in IF/ID. It also expands LM/SM (load/store multiple) instructions into one transfer micro-op per cycle. While an expansion is in progress it holds IF/ID and the PC, and the pipeline downstream sees a plain sequence of single-register loads/stores.

Parameters:
- ORDER_MSB_FIRST, 0: 0 = transfer lowest set mask bit first; 1 = highest first.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ir_id  in  16  instruction word from IF/ID
- valid_id  in  1  ir_id holds a real instruction (not a bubble)
- stall_in  in  1  hazard unit freezes the ID stage this cycle
- flush  in  1  branch/jump squash of the ID stage
- reg1add_id  out  3  source A / base register (RA)
- reg2add_id  out  3  source B / SM data register
- reg3add_id  out  3  destination register
- imm6_id  out  6  6-bit immediate; transfer index k during LM/SM
- imm9_id  out  9  9-bit immediate field
- is_lm  out  1  current micro-op is an LM transfer
- is_sm  out  1  current micro-op is an SM transfer
- uop_valid  out  1  outputs describe a real micro-op; 0 = bubble
- last_uop  out  1  final micro-op of the current instruction
- hold_ifid  out  1  IF/ID and PC must not advance next edge

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state:
  - state = IDLE; mask_r = 0; ra_r = 0; k_r = 0; op_r = 0.
  - While rst_n = 0, uop_valid, hold_ifid, is_lm, is_sm and last_uop are forced to 0.
  - Other outputs follow the IDLE pass-through function.
- Outputs are combinational from state, latched registers and ir_id. The ID/RD register supplies the pipeline stage. Latency from an instruction appearing to its first micro-op is 0 cycles.
- Pass-through (IDLE, not LM/SM):
  - reg1add = ir[11:9], reg2add = ir[8:6], reg3add = ir[5:3].
  - imm6 = ir[5:0], imm9 = ir[8:0].
  - uop_valid = valid_id; last_uop = 1; hold = 0.
- LM/SM encoding: opcode ir[15:12] is OP_LM or OP_SM. RA = ir[11:9]. mask = ir[7:0]; bit i selects register Ri.
- Micro-op fields for transfer k to register Rn:
  - reg1add = RA; imm6 = {3'b000, k}. Memory address is RA + k, computed downstream.
  - LM: reg3add = Rn, is_lm = 1.
  - SM: reg2add = Rn, is_sm = 1.
  - Unused address fields are 0.
- FSM states IDLE, SEQ:
  - IDLE, LM/SM, mask == 0: one bubble cycle (uop_valid = 0, last_uop = 1, hold = 0). Stay in IDLE.
  - IDLE, LM/SM, popcount == 1: single micro-op, k = 0, last_uop = 1, hold = 0. Stay in IDLE.
  - IDLE, LM/SM, popcount > 1: emit first transfer (k = 0) and assert hold = 1. At the edge, latch mask_r = mask with the emitted bit cleared, ra_r = RA, op_r = opcode, k_r = 1. Go to SEQ.
  - SEQ: emit the transfer for the next bit of mask_r per ORDER_MSB_FIRST, with k = k_r. ir_id is ignored.
    - If more than one bit remains: hold = 1, last_uop = 0. At the edge, clear the emitted bit and increment k_r.
    - If exactly one bit remains: hold = 0, last_uop = 1. Return to IDLE at the edge.
- stall_in = 1: no state, mask_r or k_r update. Outputs remain stable. hold_ifid = 1 is asserted in every state.
- flush = 1 (has priority over stall_in):
  - uop_valid = 0, hold_ifid = 0 in the same cycle.
  - Next state IDLE; mask_r and k_r cleared.
  - A partially issued LM/SM is abandoned.
- Reset mid-SEQ: returns to IDLE immediately and asynchronously. No further micro-ops are emitted.
- Width rules: k_r is 3 bits and never exceeds 7 (maximum 8 transfers). Popcount is computed over 8 bits.
- valid_id = 0 in IDLE: bubble; no transition.

Decomposition:
- Package isa_pkg holds:
  - opcode constants OP_LM = 4'b0110, OP_SM = 4'b0111;
  - the field bit positions;
  - the FSM state typedef (IDLE, SEQ).
- One sub-module, lmsm_pick: combinational priority picker over an 8-bit mask.
  - Outputs: selected index (3 bits), one-hot clear mask, "exactly one bit" flag.
  - Honours ORDER_MSB_FIRST.

Test Plan:
- ADD ir = 16'h0_5_D_8 (ir[11:9]=2, ir[8:6]=7, ir[5:3]=3), valid_id = 1 -> reg1add = 2, reg2add = 7, reg3add = 3, uop_valid = 1, hold = 0, last_uop = 1.
- LM RA = 3, mask = 8'b0010_0101 -> three micro-ops over three cycles:
  - cycle 0: reg3add = 0, imm6 = 0, hold = 1;
  - cycle 1: reg3add = 2, imm6 = 1, hold = 1;
  - cycle 2: reg3add = 5, imm6 = 2, hold = 0, last_uop = 1;
  - reg1add = 3 throughout.
- SM RA = 1, mask = 8'h80 -> single micro-op: reg2add = 7, is_sm = 1, hold = 0, last_uop = 1. mask = 8'h00 -> uop_valid = 0 for one cycle.
- LM mask = 8'hFF with stall_in high for 2 cycles during k = 3 -> reg3add = 3 / imm6 = 3 held for 3 cycles in total. Sequence then completes at k = 7 with last_uop = 1, 10 cycles total.
- SM mask = 8'h0F, flush asserted during k = 1 -> uop_valid = 0 that cycle and FSM in IDLE next cycle. The next instruction passes through normally.
- rst_n pulsed low mid-SEQ -> uop_valid and hold drop immediately. After release, an LM with mask 8'h03 starts again at k = 0.
